// File: rtl/dmem_bridge.sv
// Data-memory bridge: posted-write FIFO with store-to-load forwarding in front of
// a single-outstanding ready/valid bus. Loads that miss the buffer drain it first.
module dmem_bridge #(
  parameter int ADDR_W   = 32,
  parameter int WB_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memwrite,
  input  logic              memread,
  input  logic [ADDR_W-1:0] memaddr,
  input  logic [31:0]       memwritedata,
  output logic [31:0]       memreaddata,
  output logic              stall,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ready,
  input  logic [31:0]       bus_rdata
);

  localparam int PTR_W = $clog2(WB_DEPTH);
  localparam int CNT_W = $clog2(WB_DEPTH + 1);
  localparam int WA_W  = ADDR_W - 2;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(WB_DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [WA_W-1:0]   wb_addr [WB_DEPTH];
  logic [31:0]       wb_data [WB_DEPTH];

  logic [WA_W-1:0]   mem_word;
  logic              is_load;
  logic              hit;
  logic [31:0]       fwd_data;
  logic              drain, push, pop;
  logic              stall_c;
  logic              unused_byte_bits;

  assign mem_word         = memaddr[ADDR_W-1:2];
  assign unused_byte_bits = ^memaddr[1:0];
  // A simultaneous read+write is a store, so it never forwards or starts a read.
  assign is_load          = memread & ~memwrite;

  assign drain = (count_q != '0) && (state_q != RD_WAIT);
  assign pop   = drain && bus_ready;
  // Fullness is judged on the current count; a same-cycle pop does not free a slot.
  assign push  = (state_q == IDLE) && memwrite && (count_q != FULL);

  // Oldest-to-newest scan so the newest matching entry wins.
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if ((CNT_W'(i) < count_q) && (wb_addr[rd_ptr_q + PTR_W'(i)] == mem_word)) begin
        hit      = 1'b1;
        fwd_data = wb_data[rd_ptr_q + PTR_W'(i)];
      end
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    rdata_d     = rdata_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    stall_c     = 1'b0;
    bus_req     = 1'b0;
    bus_we      = 1'b0;
    bus_addr    = {wb_addr[rd_ptr_q], 2'b00};
    bus_wdata   = wb_data[rd_ptr_q];
    memreaddata = rdata_q;

    if (drain) begin
      bus_req = 1'b1;
      bus_we  = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (memwrite) begin
          stall_c = (count_q == FULL);
        end else if (is_load) begin
          if (hit) begin
            memreaddata = fwd_data;
          end else begin
            stall_c = 1'b1;
            if (count_q == '0) state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        stall_c  = 1'b1;
        bus_req  = 1'b1;
        bus_we   = 1'b0;
        bus_addr = {mem_word, 2'b00};
        if (bus_ready) begin
          rdata_d = bus_rdata;
          state_d = RD_DONE;
        end
      end
      RD_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Gated so a reset during a stalled load releases the CPU immediately.
  assign stall = stall_c & reset;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rdata_q  <= rdata_d;
    end
  end

  // NOTE: buffer storage is not reset; an entry is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (push) begin
      wb_addr[wr_ptr_q] <= mem_word;
      wb_data[wr_ptr_q] <= memwritedata;
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: directed vector table, reset corner cases,
// and randomized CPU/bus traffic against a queue-based reference model.
module tb_dmem_bridge;

  localparam int ADDR_W = 32;
  localparam int DEPTH  = 2;

  logic        clk, reset;
  logic        memwrite, memread;
  logic [31:0] memaddr, memwritedata, memreaddata;
  logic        stall, bus_req, bus_we, bus_ready;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_bridge #(.ADDR_W(ADDR_W), .WB_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .memwrite     (memwrite),
    .memread      (memread),
    .memaddr      (memaddr),
    .memwritedata (memwritedata),
    .memreaddata  (memreaddata),
    .stall        (stall),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_ready    (bus_ready),
    .bus_rdata    (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        wr, rd;
    logic [31:0] addr, wdata;
    logic        rdy;
    logic [31:0] rdata;
    logic        e_stall, e_req, e_we;
    logic [31:0] e_addr, e_wdata, e_rd;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic wr, input logic rd, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic rdy, input logic [31:0] rdata,
                              input logic es, input logic er, input logic ew,
                              input logic [31:0] ea, input logic [31:0] ewd, input logic [31:0] erd);
    vec_t v;
    v.wr = wr; v.rd = rd; v.addr = addr; v.wdata = wdata; v.rdy = rdy; v.rdata = rdata;
    v.e_stall = es; v.e_req = er; v.e_we = ew; v.e_addr = ea; v.e_wdata = ewd; v.e_rd = erd;
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic wr, input logic rd, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic rdy, input logic [31:0] rdata);
    memwrite = wr; memread = rd; memaddr = addr; memwritedata = wdata;
    bus_ready = rdy; bus_rdata = rdata;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    next_cycle();
    next_cycle();
    reset = 1'b1;
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [29:0] word;
    logic [31:0] data;
  } wb_t;

  wb_t         m_q[$];
  logic        m_rd_wait, m_rd_done, m_hit, m_hold;
  logic [31:0] m_rdata;
  logic        e_stall, e_req, e_we;
  logic [31:0] e_addr, e_wdata, e_rd;

  task automatic model_eval();
    logic [29:0] word;
    word    = memaddr[31:2];
    e_stall = 0; e_req = 0; e_we = 0; e_addr = 0; e_wdata = 0;
    e_rd    = m_rdata;
    m_hit   = 0;
    if (m_rd_wait) begin
      e_stall = 1; e_req = 1; e_addr = {word, 2'b00};
    end else begin
      if (m_q.size() > 0) begin
        e_req = 1; e_we = 1;
        e_addr  = {m_q[0].word, 2'b00};
        e_wdata = m_q[0].data;
      end
      if (!m_rd_done) begin
        if (memwrite) begin
          e_stall = (m_q.size() == DEPTH);
        end else if (memread) begin
          foreach (m_q[i]) if (m_q[i].word == word) begin m_hit = 1; e_rd = m_q[i].data; end
          if (!m_hit) e_stall = 1;
        end
      end
    end
  endtask

  task automatic model_update();
    int   n;
    logic idle;
    wb_t  e;
    n    = m_q.size();
    idle = !m_rd_wait && !m_rd_done;
    if (e_req && e_we && bus_ready) void'(m_q.pop_front());
    if (idle && memwrite && n < DEPTH) begin
      e.word = memaddr[31:2]; e.data = memwritedata;
      m_q.push_back(e);
    end
    if (m_rd_wait) begin
      if (bus_ready) begin m_rdata = bus_rdata; m_rd_wait = 0; m_rd_done = 1; end
    end else if (m_rd_done) begin
      m_rd_done = 0;
    end else if (idle && memread && !memwrite && !m_hit && n == 0) begin
      m_rd_wait = 1;
    end
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #2;
    check("reset_stall",   32'(stall),   0);
    check("reset_bus_req", 32'(bus_req), 0);
    check("reset_rdata",   memreaddata,  0);
    next_cycle();
    next_cycle();
    reset = 1'b1;

    //  wr rd addr        wdata  rdy rdata        stl req we  e_addr      e_wdata  e_rd
    // posted stores, full stall without pop bypass, simultaneous push/pop, order
    add(1, 0, 32'h100, 32'h11, 0, 0,            0, 0, 0, 0,          0,       0);
    add(1, 0, 32'h104, 32'h22, 0, 0,            0, 1, 1, 32'h100,    32'h11,  0);
    add(1, 0, 32'h108, 32'h33, 0, 0,            1, 1, 1, 32'h100,    32'h11,  0);
    add(1, 0, 32'h108, 32'h33, 1, 0,            1, 1, 1, 32'h100,    32'h11,  0);
    add(1, 0, 32'h108, 32'h33, 1, 0,            0, 1, 1, 32'h104,    32'h22,  0);
    add(0, 0, 0,       0,      0, 0,            0, 1, 1, 32'h108,    32'h33,  0);
    add(0, 0, 0,       0,      1, 0,            0, 1, 1, 32'h108,    32'h33,  0);
    add(0, 0, 0,       0,      0, 0,            0, 0, 0, 0,          0,       0);
    // forwarding from the newest match, then a miss that drains first
    add(1, 0, 32'h100, 32'h11, 0, 0,            0, 0, 0, 0,          0,       0);
    add(1, 0, 32'h100, 32'h33, 0, 0,            0, 1, 1, 32'h100,    32'h11,  0);
    add(0, 1, 32'h102, 0,      0, 0,            0, 1, 1, 32'h100,    32'h11,  32'h33);
    add(0, 1, 32'h200, 0,      1, 0,            1, 1, 1, 32'h100,    32'h11,  0);
    add(0, 1, 32'h200, 0,      1, 0,            1, 1, 1, 32'h100,    32'h33,  0);
    add(0, 1, 32'h200, 0,      0, 0,            1, 0, 0, 0,          0,       0);
    add(0, 1, 32'h200, 0,      0, 0,            1, 1, 0, 32'h200,    0,       0);
    add(0, 1, 32'h200, 0,      1, 32'hBEEF,     1, 1, 0, 32'h200,    0,       0);
    add(0, 1, 32'h200, 0,      0, 0,            0, 0, 0, 0,          0,       32'hBEEF);
    add(0, 0, 0,       0,      0, 0,            0, 0, 0, 0,          0,       32'hBEEF);
    // minimum-latency miss with bus_ready high
    add(0, 1, 32'h200, 0,      1, 32'hCAFE,     1, 0, 0, 0,          0,       32'hBEEF);
    add(0, 1, 32'h200, 0,      1, 32'hCAFE,     1, 1, 0, 32'h200,    0,       32'hBEEF);
    add(0, 1, 32'h200, 0,      1, 32'hCAFE,     0, 0, 0, 0,          0,       32'hCAFE);
    // write 0x300 reaches the bus before read 0x400
    add(1, 0, 32'h300, 32'h44, 0, 0,            0, 0, 0, 0,          0,       32'hCAFE);
    add(0, 1, 32'h400, 0,      1, 32'h55,       1, 1, 1, 32'h300,    32'h44,  32'hCAFE);
    add(0, 1, 32'h400, 0,      1, 32'h55,       1, 0, 0, 0,          0,       32'hCAFE);
    add(0, 1, 32'h400, 0,      1, 32'h55,       1, 1, 0, 32'h400,    0,       32'hCAFE);
    add(0, 1, 32'h400, 0,      1, 32'h55,       0, 0, 0, 0,          0,       32'h55);
    // read+write together is a store
    add(1, 1, 32'h500, 32'h66, 0, 0,            0, 0, 0, 0,          0,       32'h55);
    add(0, 0, 0,       0,      0, 0,            0, 1, 1, 32'h500,    32'h66,  32'h55);
    add(0, 0, 0,       0,      1, 0,            0, 1, 1, 32'h500,    32'h66,  32'h55);
    add(0, 0, 0,       0,      0, 0,            0, 0, 0, 0,          0,       32'h55);
    // byte offsets ignored on bus and in forwarding
    add(1, 0, 32'h10B, 32'h77, 0, 0,            0, 0, 0, 0,          0,       32'h55);
    add(0, 1, 32'h109, 0,      0, 0,            0, 1, 1, 32'h108,    32'h77,  32'h77);
    add(0, 0, 0,       0,      1, 0,            0, 1, 1, 32'h108,    32'h77,  32'h55);
    add(0, 0, 0,       0,      0, 0,            0, 0, 0, 0,          0,       32'h55);

    foreach (vecs[i]) begin
      drive(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].rdy, vecs[i].rdata);
      #3;
      check($sformatf("vec%0d_stall", i), 32'(stall),   32'(vecs[i].e_stall));
      check($sformatf("vec%0d_req", i),   32'(bus_req), 32'(vecs[i].e_req));
      check($sformatf("vec%0d_rd", i),    memreaddata,  vecs[i].e_rd);
      if (vecs[i].e_req) begin
        check($sformatf("vec%0d_we", i),   32'(bus_we), 32'(vecs[i].e_we));
        check($sformatf("vec%0d_addr", i), bus_addr,    vecs[i].e_addr);
        if (vecs[i].e_we) check($sformatf("vec%0d_wdata", i), bus_wdata, vecs[i].e_wdata);
      end
      next_cycle();
    end

    // reset while a read is waiting on the bus
    drive(0, 1, 32'h600, 0, 0, 0);
    next_cycle();
    check("rdwait_req", 32'(bus_req), 1);
    check("rdwait_stall", 32'(stall), 1);
    reset = 1'b0;
    #1;
    check("rstmid_req",   32'(bus_req), 0);
    check("rstmid_stall", 32'(stall),   0);
    check("rstmid_rdata", memreaddata,  0);
    next_cycle();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    next_cycle();

    // reset discards buffered writes
    drive(1, 0, 32'h700, 32'h99, 0, 0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check("buffered_req", 32'(bus_req), 1);
    reset = 1'b0;
    #1;
    check("rstbuf_req",   32'(bus_req),       0);
    check("rstbuf_count", 32'(dut.count_q),   0);
    next_cycle();
    reset = 1'b1;
    #2;
    check("post_rst_req",   32'(bus_req), 0);
    check("post_rst_stall", 32'(stall),   0);
    next_cycle();

    // randomized traffic against the reference model
    do_reset();
    m_q.delete();
    m_rd_wait = 0; m_rd_done = 0; m_rdata = 0; m_hold = 0;
    for (int c = 0; c < 600; c++) begin
      if (!m_hold) begin
        int r;
        r = $urandom_range(0, 9);
        memwrite     = (r < 4);
        memread      = (r >= 4 && r < 7) || (r == 0);
        memaddr      = 32'h100 + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 3));
        memwritedata = $urandom;
      end
      bus_ready = 1'($urandom_range(0, 1));
      bus_rdata = $urandom;
      #3;
      model_eval();
      check($sformatf("rnd%0d_stall", c), 32'(stall),   32'(e_stall));
      check($sformatf("rnd%0d_req", c),   32'(bus_req), 32'(e_req));
      check($sformatf("rnd%0d_rd", c),    memreaddata,  e_rd);
      if (e_req) begin
        check($sformatf("rnd%0d_we", c),   32'(bus_we), 32'(e_we));
        check($sformatf("rnd%0d_addr", c), bus_addr,    e_addr);
        if (e_we) check($sformatf("rnd%0d_wdata", c), bus_wdata, e_wdata);
      end
      m_hold = e_stall;
      model_update();
      next_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
